// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared constants and types for the immediate group allocator
package imm_pkg;

    localparam int IMM_SLOTS      = 4;
    localparam int WIDTH_ADDR_DEF = 5;
    localparam int GROUPS         = (2 ** WIDTH_ADDR_DEF) / IMM_SLOTS;
    localparam int GROUP_IDX_W    = $clog2(GROUPS);

    // Per-group mask of slots still awaiting release by issue
    typedef logic [IMM_SLOTS-1:0] imm_group_t;

endpackage

// File: rtl/imm_penc.sv
// rtl/imm_penc.sv - lowest-set-bit priority encoder with one-hot, binary and any outputs
module imm_penc
    import imm_pkg::*;
#(
    parameter int N  = GROUPS,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_vec,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // Scan from the top down so the lowest set bit is the last one to win
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = |i_vec;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
                o_idx       = IW'(i);
            end
        end
    end

endmodule

// File: rtl/imm4_alloc.sv
// rtl/imm4_alloc.sv - allocates 4-slot immediate groups and drives the imm4 write port
module imm4_alloc
    import imm_pkg::*;
#(
    parameter int WIDTH_ADDR = 5,
    parameter int WIDTH      = 32
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_flush,
    input  logic                                i_valid,
    input  logic [3:0]                          i_mask,
    input  logic [WIDTH-1:0]                    i_imm0,
    input  logic [WIDTH-1:0]                    i_imm1,
    input  logic [WIDTH-1:0]                    i_imm2,
    input  logic [WIDTH-1:0]                    i_imm3,
    output logic                                o_ready,
    output logic [WIDTH_ADDR-1:0]               o_tag,
    input  logic [3:0]                          i_rel_en,
    input  logic [WIDTH_ADDR-1:0]               i_rel_idx0,
    input  logic [WIDTH_ADDR-1:0]               i_rel_idx1,
    input  logic [WIDTH_ADDR-1:0]               i_rel_idx2,
    input  logic [WIDTH_ADDR-1:0]               i_rel_idx3,
    output logic                                o_we,
    output logic [(2**WIDTH_ADDR)/IMM_SLOTS-1:0] o_waddr,
    output logic [WIDTH-1:0]                    o_wdata0,
    output logic [WIDTH-1:0]                    o_wdata1,
    output logic [WIDTH-1:0]                    o_wdata2,
    output logic [WIDTH-1:0]                    o_wdata3
);

    localparam int NUM_GROUPS = (2 ** WIDTH_ADDR) / IMM_SLOTS;
    localparam int GW         = WIDTH_ADDR - 2;

    imm_group_t              pend_q [NUM_GROUPS];
    imm_group_t              pend_d [NUM_GROUPS];
    logic [NUM_GROUPS-1:0]   free_vec;
    logic [NUM_GROUPS-1:0]   sel_onehot;
    logic [GW-1:0]           sel_idx;
    logic                    any_free;
    logic                    accept;
    logic [WIDTH_ADDR-1:0]   rel_idx [IMM_SLOTS];

    logic                    we_q,    we_d;
    logic [NUM_GROUPS-1:0]   waddr_q, waddr_d;
    logic [WIDTH-1:0]        wdata_q [IMM_SLOTS];
    logic [WIDTH-1:0]        wdata_d [IMM_SLOTS];

    assign rel_idx[0] = i_rel_idx0;
    assign rel_idx[1] = i_rel_idx1;
    assign rel_idx[2] = i_rel_idx2;
    assign rel_idx[3] = i_rel_idx3;

    // A group is free once every slot it claimed has been released
    always_comb begin
        free_vec = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            free_vec[g] = (pend_q[g] == '0);
        end
    end

    imm_penc #(
        .N  (NUM_GROUPS),
        .IW (GW)
    ) u_penc (
        .i_vec    (free_vec),
        .o_onehot (sel_onehot),
        .o_idx    (sel_idx),
        .o_any    (any_free)
    );

    // Ready and tag depend only on registered state, never on this cycle's requests
    assign o_ready = any_free & ~i_rst;
    assign o_tag   = any_free ? {sel_idx, 2'b00} : '0;
    assign accept  = i_valid & o_ready & (|i_mask) & ~i_flush;

    // Releases first, then allocation so a same-cycle release cannot clear new bits; flush wins
    always_comb begin
        for (int g = 0; g < NUM_GROUPS; g++) begin
            pend_d[g] = pend_q[g];
        end
        for (int k = 0; k < IMM_SLOTS; k++) begin
            if (i_rel_en[k]) begin
                pend_d[rel_idx[k][WIDTH_ADDR-1:2]][rel_idx[k][1:0]] = 1'b0;
            end
        end
        if (accept) begin
            pend_d[sel_idx] = i_mask;
        end
        if (i_flush) begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                pend_d[g] = '0;
            end
        end
    end

    // Write-port stage: all four immediates are written, address and data hold when idle
    always_comb begin
        we_d    = accept;
        waddr_d = accept ? sel_onehot : waddr_q;
        wdata_d[0] = accept ? i_imm0 : wdata_q[0];
        wdata_d[1] = accept ? i_imm1 : wdata_q[1];
        wdata_d[2] = accept ? i_imm2 : wdata_q[2];
        wdata_d[3] = accept ? i_imm3 : wdata_q[3];
    end

    // State registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                pend_q[g] <= '0;
            end
            we_q    <= 1'b0;
            waddr_q <= '0;
            for (int k = 0; k < IMM_SLOTS; k++) begin
                wdata_q[k] <= '0;
            end
        end else begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                pend_q[g] <= pend_d[g];
            end
            we_q    <= we_d;
            waddr_q <= waddr_d;
            for (int k = 0; k < IMM_SLOTS; k++) begin
                wdata_q[k] <= wdata_d[k];
            end
        end
    end

    assign o_we     = we_q;
    assign o_waddr  = waddr_q;
    assign o_wdata0 = wdata_q[0];
    assign o_wdata1 = wdata_q[1];
    assign o_wdata2 = wdata_q[2];
    assign o_wdata3 = wdata_q[3];

endmodule
